// File: rtl/median_buf_wr.sv
// Sample-to-buffer write sequencer: turns sample strobes into addressed write
// pulses and flags the reader once the buffer is full (hold or auto-rearm mode).
module median_buf_wr #(
    parameter  int DATA_W     = 16,
    parameter  int DEPTH      = 8,
    parameter  int AUTO_REARM = 0,
    localparam int ADDR_W     = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              rstn_i,
    input  logic [DATA_W-1:0] median_i,
    input  logic              control_i,
    input  logic              rd_done_i,
    output logic [DATA_W-1:0] wr_data,
    output logic [ADDR_W-1:0] addr,
    output logic              control_o,
    output logic              control_rd,
    output logic              ready_o,
    output logic [ADDR_W:0]   fill_o,
    output logic              ovf_o
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] STROBE = 2'd1;
    localparam logic [1:0] COMMIT = 2'd2;
    localparam logic [1:0] FULL   = 2'd3;

    logic [1:0]        state_q, state_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W:0]   fill_q, fill_d;
    logic              control_o_q, control_o_d;
    logic              control_rd_q, control_rd_d;
    logic              ovf_q, ovf_d;
    logic              last_slot;

    assign last_slot = (wr_ptr_q == ADDR_W'(DEPTH - 1));

    always_comb begin
        state_d      = state_q;
        wr_data_d    = wr_data_q;
        addr_d       = addr_q;
        wr_ptr_d     = wr_ptr_q;
        fill_d       = fill_q;
        control_o_d  = 1'b0;
        control_rd_d = 1'b0;
        ovf_d        = ovf_q;
        case (state_q)
            IDLE: begin
                if (control_i) begin
                    wr_data_d = median_i;
                    state_d   = STROBE;
                end
            end
            STROBE: begin
                control_o_d = 1'b1;
                addr_d      = wr_ptr_q;
                state_d     = COMMIT;
            end
            COMMIT: begin
                fill_d   = fill_q + (ADDR_W + 1)'(1);
                wr_ptr_d = wr_ptr_q + ADDR_W'(1);
                state_d  = IDLE;
                if (last_slot) begin
                    control_rd_d = 1'b1;
                    if (AUTO_REARM != 0) begin
                        fill_d   = '0;
                        wr_ptr_d = '0;
                    end else begin
                        state_d = FULL;
                    end
                end
            end
            default: begin
                control_rd_d = 1'b1;
                if (rd_done_i) begin
                    control_rd_d = 1'b0;
                    fill_d       = '0;
                    ovf_d        = 1'b0;
                    wr_ptr_d     = '0;
                    state_d      = IDLE;
                end
            end
        endcase
        // A drop always wins over the re-arm clear of the overflow flag.
        if (control_i && (state_q != IDLE)) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q      <= IDLE;
            wr_data_q    <= '0;
            addr_q       <= '0;
            wr_ptr_q     <= '0;
            fill_q       <= '0;
            control_o_q  <= 1'b0;
            control_rd_q <= 1'b0;
            ovf_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_data_q    <= wr_data_d;
            addr_q       <= addr_d;
            wr_ptr_q     <= wr_ptr_d;
            fill_q       <= fill_d;
            control_o_q  <= control_o_d;
            control_rd_q <= control_rd_d;
            ovf_q        <= ovf_d;
        end
    end

    assign wr_data    = wr_data_q;
    assign addr       = addr_q;
    assign control_o  = control_o_q;
    assign control_rd = control_rd_q;
    assign ready_o    = (state_q == IDLE);
    assign fill_o     = fill_q;
    assign ovf_o      = ovf_q;

endmodule

// File: tb/tb_median_buf_wr.sv
// Bench for median_buf_wr: a hold-mode instance (DEPTH=8) and an auto-rearm
// instance (DEPTH=4) driven by directed and random samples, scoreboard-checked.
module tb_median_buf_wr;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        ctl0 = 1'b0, done0 = 1'b0, ctl1 = 1'b0, done1 = 1'b0;
    logic [15:0] med0 = '0, med1 = '0;

    logic [15:0] wrData0, wrData1;
    logic [2:0]  addr0;
    logic [1:0]  addr1;
    logic [3:0]  fill0;
    logic [2:0]  fill1;
    logic        we0, we1, rd0, rd1, rdy0, rdy1, ovf0, ovf1;

    int errors = 0;
    int checks = 0;

    // Reference model: one entry per instance, built from the buffer rules.
    int          phase[2];
    int          fillM[2];
    int          ptrM[2];
    int          ovfM[2];
    int          weM[2];
    int          pulseM[2];
    int          addrM[2];
    logic [15:0] dataM[2];
    int          depthM[2] = '{8, 4};
    int          arM[2]    = '{0, 1};
    logic [31:0] sbq0[$];
    logic [31:0] sbq1[$];

    median_buf_wr #(.DATA_W(16), .DEPTH(8), .AUTO_REARM(0)) dut0 (
        .clk_i(clk), .rstn_i(rstn), .median_i(med0), .control_i(ctl0),
        .rd_done_i(done0), .wr_data(wrData0), .addr(addr0), .control_o(we0),
        .control_rd(rd0), .ready_o(rdy0), .fill_o(fill0), .ovf_o(ovf0));

    median_buf_wr #(.DATA_W(16), .DEPTH(4), .AUTO_REARM(1)) dut1 (
        .clk_i(clk), .rstn_i(rstn), .median_i(med1), .control_i(ctl1),
        .rd_done_i(done1), .wr_data(wrData1), .addr(addr1), .control_o(we1),
        .control_rd(rd1), .ready_o(rdy1), .fill_o(fill1), .ovf_o(ovf1));

    always #5 clk = ~clk;

    task automatic cmp(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic resetModel();
        for (int k = 0; k < 2; k++) begin
            phase[k] = 0; fillM[k] = 0; ptrM[k] = 0; ovfM[k] = 0;
            weM[k] = 0; pulseM[k] = 0; addrM[k] = 0; dataM[k] = '0;
        end
        sbq0.delete();
        sbq1.delete();
    endtask

    // phase: 0 waiting for a sample, 1/2 the two busy cycles of a write,
    // 3 buffer full awaiting the reader's acknowledge.
    task automatic modelEdge(input int k, input logic c, input logic d, input logic [15:0] m);
        weM[k] = 0;
        pulseM[k] = 0;
        if (c && phase[k] != 0) ovfM[k] = 1;
        case (phase[k])
            0: if (c) begin
                dataM[k] = m;
                if (k == 0) sbq0.push_back({16'(ptrM[k]), m});
                else        sbq1.push_back({16'(ptrM[k]), m});
                phase[k] = 1;
            end
            1: begin
                weM[k] = 1;
                addrM[k] = ptrM[k];
                phase[k] = 2;
            end
            2: begin
                fillM[k]++;
                ptrM[k] = (ptrM[k] + 1) % depthM[k];
                phase[k] = 0;
                if (fillM[k] == depthM[k]) begin
                    if (arM[k] != 0) begin
                        pulseM[k] = 1; fillM[k] = 0; ptrM[k] = 0;
                    end else begin
                        phase[k] = 3;
                    end
                end
            end
            default: if (d) begin
                fillM[k] = 0; ptrM[k] = 0; phase[k] = 0;
                ovfM[k] = c ? 1 : 0;
            end
        endcase
    endtask

    task automatic checkOutput(input int k);
        int rdy, we, rd, fl, ov, ad, wd;
        if (k == 0) begin
            rdy = int'(rdy0); we = int'(we0); rd = int'(rd0); fl = int'(fill0);
            ov = int'(ovf0); ad = int'(addr0); wd = int'(wrData0);
        end else begin
            rdy = int'(rdy1); we = int'(we1); rd = int'(rd1); fl = int'(fill1);
            ov = int'(ovf1); ad = int'(addr1); wd = int'(wrData1);
        end
        cmp($sformatf("u%0d.ready_o", k), rdy, (phase[k] == 0) ? 1 : 0);
        cmp($sformatf("u%0d.control_o", k), we, weM[k]);
        cmp($sformatf("u%0d.control_rd", k), rd, (phase[k] == 3 || pulseM[k] != 0) ? 1 : 0);
        cmp($sformatf("u%0d.fill_o", k), fl, fillM[k]);
        cmp($sformatf("u%0d.ovf_o", k), ov, ovfM[k]);
        cmp($sformatf("u%0d.addr", k), ad, addrM[k]);
        cmp($sformatf("u%0d.wr_data", k), wd, int'(dataM[k]));
    endtask

    task automatic stepCycle();
        @(posedge clk);
        modelEdge(0, ctl0, done0, med0);
        modelEdge(1, ctl1, done1, med1);
        @(negedge clk);
        checkOutput(0);
        checkOutput(1);
    endtask

    task automatic applyStimulus(input int k, input logic c, input logic d, input logic [15:0] m);
        ctl0 = (k == 0) ? c : 1'b0; done0 = (k == 0) ? d : 1'b0; med0 = (k == 0) ? m : '0;
        ctl1 = (k == 1) ? c : 1'b0; done1 = (k == 1) ? d : 1'b0; med1 = (k == 1) ? m : '0;
        stepCycle();
        ctl0 = 1'b0; done0 = 1'b0; ctl1 = 1'b0; done1 = 1'b0;
    endtask

    task automatic checkReset(input string tag);
        cmp({tag, ".ready"}, int'({rdy0, rdy1}), 3);
        cmp({tag, ".strobes"}, int'({we0, we1, rd0, rd1, ovf0, ovf1}), 0);
        cmp({tag, ".data"}, int'(wrData0) + int'(wrData1), 0);
        cmp({tag, ".addr_fill"}, int'({addr0, addr1, fill0, fill1}), 0);
    endtask

    // Scoreboard monitor: every write strobe must match the oldest accepted sample.
    always @(negedge clk) begin
        logic [31:0] e;
        if (rstn && we0) begin
            if (sbq0.size() == 0) cmp("u0.unexpected_write", 1, 0);
            else begin
                e = sbq0.pop_front();
                cmp("u0.sb_addr", int'(addr0), int'(e[31:16]));
                cmp("u0.sb_data", int'(wrData0), int'(e[15:0]));
            end
        end
        if (rstn && we1) begin
            if (sbq1.size() == 0) cmp("u1.unexpected_write", 1, 0);
            else begin
                e = sbq1.pop_front();
                cmp("u1.sb_addr", int'(addr1), int'(e[31:16]));
                cmp("u1.sb_data", int'(wrData1), int'(e[15:0]));
            end
        end
    end

    initial begin
        int guard;
        resetModel();
        #1 checkReset("reset");
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b1;

        // Single write, then fill the hold-mode buffer with 2..8.
        applyStimulus(0, 1'b1, 1'b0, 16'hA5A5);
        repeat (3) applyStimulus(0, 1'b0, 1'b0, '0);
        for (int i = 2; i <= 8; i++) begin
            applyStimulus(0, 1'b1, 1'b0, 16'(i));
            repeat (2) applyStimulus(0, 1'b0, 1'b0, '0);
        end
        repeat (2) applyStimulus(0, 1'b0, 1'b0, '0);

        // Overflow while full, acknowledge, next sample back at addr 0.
        applyStimulus(0, 1'b1, 1'b0, 16'h1234);
        applyStimulus(0, 1'b0, 1'b0, '0);
        applyStimulus(0, 1'b0, 1'b1, '0);
        applyStimulus(0, 1'b1, 1'b0, 16'h0077);
        repeat (3) applyStimulus(0, 1'b0, 1'b0, '0);

        // Control held for three cycles: only the first is written.
        repeat (3) applyStimulus(0, 1'b1, 1'b0, 16'hC0DE);
        repeat (3) applyStimulus(0, 1'b0, 1'b0, '0);

        // Auto-rearm instance: five samples, no stall after the wrap.
        for (int i = 1; i <= 5; i++) begin
            applyStimulus(1, 1'b1, 1'b0, 16'(16'h100 + i));
            repeat (2) applyStimulus(1, 1'b0, 1'b0, '0);
        end

        // Fill hold instance again, then drop and acknowledge in the same cycle.
        guard = 0;
        while (phase[0] != 3 && guard < 100) begin
            applyStimulus(0, 1'b1, 1'b0, 16'(16'h200 + guard));
            guard++;
        end
        cmp("u0.refill_reached_full", (guard < 100) ? 1 : 0, 1);
        applyStimulus(0, 1'b1, 1'b1, 16'hDEAD);
        repeat (2) applyStimulus(0, 1'b0, 1'b0, '0);

        // Asynchronous reset while in STROBE aborts the write.
        applyStimulus(0, 1'b1, 1'b0, 16'hBEEF);
        rstn = 1'b0;
        #1 checkReset("midreset");
        resetModel();
        @(negedge clk);
        rstn = 1'b1;
        applyStimulus(0, 1'b1, 1'b0, 16'h4321);
        repeat (3) applyStimulus(0, 1'b0, 1'b0, '0);

        // Random traffic on both instances.
        for (int n = 0; n < 600; n++) begin
            ctl0 = ($urandom_range(0, 2) == 0); done0 = ($urandom_range(0, 3) == 0);
            med0 = 16'($urandom);
            ctl1 = ($urandom_range(0, 2) == 0); done1 = ($urandom_range(0, 3) == 0);
            med1 = 16'($urandom);
            stepCycle();
        end
        applyStimulus(0, 1'b0, 1'b0, '0);
        repeat (3) applyStimulus(0, 1'b0, 1'b0, '0);

        cmp("u0.sb_leftover", sbq0.size(), 0);
        cmp("u1.sb_leftover", sbq1.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
